// File: rtl/axil_pkg.sv
// Shared state encoding and AXI constants for the AXI-Lite single master.
package axil_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    RESP
  } axil_mst_state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axil_mst_watchdog.sv
// Saturating busy-cycle counter with a sticky timeout flag.
// Used by axil_single_master only when AXIL_MASTER_TIMEOUT_EN is defined.
module axil_mst_watchdog #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic active,
  output logic timeout
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] MAX = CW'(LIMIT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else if (start) begin
      cnt <= '0;
    end else if (active) begin
      if (cnt != MAX) cnt <= cnt + CW'(1);
      // flag rises on the same edge the count reaches LIMIT
      if (cnt >= MAX - CW'(1)) timeout <= 1'b1;
    end
  end

endmodule

// File: rtl/axil_single_master.sv
// AXI4-Lite single-outstanding master driven by a valid/ready command port.
// Optional watchdog flag o_timeout is built when AXIL_MASTER_TIMEOUT_EN is defined.
module axil_single_master
  import axil_pkg::*;
#(
  parameter int C_AXI_ADDR_WIDTH = 7,
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_TIMEOUT_CYCLES = 15
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESET,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_we,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic                          rsp_we,
  output logic [C_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                    rsp_resp,
`ifdef AXIL_MASTER_TIMEOUT_EN
  output logic                          o_timeout,
`endif
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [C_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                    M_AXI_AWPROT,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  output logic [C_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY,
  input  logic [1:0]                    M_AXI_BRESP,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  output logic [C_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                    M_AXI_ARPROT,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY,
  input  logic [C_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP
);

  localparam int AW = C_AXI_ADDR_WIDTH;
  localparam int DW = C_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;

  if (C_TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("C_TIMEOUT_CYCLES must be >= 1");
  end

  axil_mst_state_t state, state_nx;

  logic          cmd_rdy, cmd_rdy_nx;
  logic          aw_valid, aw_valid_nx;
  logic          w_valid, w_valid_nx;
  logic          ar_valid, ar_valid_nx;
  logic          b_ready, b_ready_nx;
  logic          r_ready, r_ready_nx;
  logic          aw_done, aw_done_nx;
  logic          w_done, w_done_nx;
  logic          rsp_vld, rsp_vld_nx;
  logic          we, we_nx;
  logic [AW-1:0] addr, addr_nx;
  logic [DW-1:0] wdata, wdata_nx;
  logic [SW-1:0] wstrb, wstrb_nx;
  logic [DW-1:0] rdata, rdata_nx;
  logic [1:0]    resp, resp_nx;

  always_comb begin
    state_nx    = state;
    aw_valid_nx = aw_valid;
    w_valid_nx  = w_valid;
    ar_valid_nx = ar_valid;
    b_ready_nx  = b_ready;
    r_ready_nx  = r_ready;
    aw_done_nx  = aw_done;
    w_done_nx   = w_done;
    rsp_vld_nx  = rsp_vld;
    we_nx       = we;
    addr_nx     = addr;
    wdata_nx    = wdata;
    wstrb_nx    = wstrb;
    rdata_nx    = rdata;
    resp_nx     = resp;
    unique case (state)
      IDLE: begin
        if (cmd_valid && cmd_rdy) begin
          we_nx    = cmd_we;
          addr_nx  = cmd_addr;
          wdata_nx = cmd_wdata;
          wstrb_nx = cmd_wstrb;
          if (cmd_we) begin
            state_nx    = WRITE;
            aw_valid_nx = 1'b1;
            w_valid_nx  = 1'b1;
            aw_done_nx  = 1'b0;
            w_done_nx   = 1'b0;
          end else begin
            state_nx    = READ;
            ar_valid_nx = 1'b1;
          end
        end
      end
      WRITE: begin
        if (aw_valid && M_AXI_AWREADY) begin
          aw_valid_nx = 1'b0;
          aw_done_nx  = 1'b1;
        end
        if (w_valid && M_AXI_WREADY) begin
          w_valid_nx = 1'b0;
          w_done_nx  = 1'b1;
        end
        if (b_ready && M_AXI_BVALID) begin
          b_ready_nx = 1'b0;
          resp_nx    = M_AXI_BRESP;
          rdata_nx   = '0;
          rsp_vld_nx = 1'b1;
          state_nx   = RESP;
        end else if (aw_done && w_done) begin
          b_ready_nx = 1'b1;
        end
      end
      READ: begin
        if (ar_valid && M_AXI_ARREADY) begin
          ar_valid_nx = 1'b0;
          r_ready_nx  = 1'b1;
        end
        if (r_ready && M_AXI_RVALID) begin
          r_ready_nx = 1'b0;
          rdata_nx   = M_AXI_RDATA;
          resp_nx    = M_AXI_RRESP;
          rsp_vld_nx = 1'b1;
          state_nx   = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_vld_nx = 1'b0;
          state_nx   = IDLE;
        end
      end
    endcase
    cmd_rdy_nx = (state_nx == IDLE);
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      state    <= IDLE;
      cmd_rdy  <= 1'b0;
      aw_valid <= 1'b0;
      w_valid  <= 1'b0;
      ar_valid <= 1'b0;
      b_ready  <= 1'b0;
      r_ready  <= 1'b0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      rsp_vld  <= 1'b0;
      we       <= 1'b0;
      addr     <= '0;
      wdata    <= '0;
      wstrb    <= '0;
      rdata    <= '0;
      resp     <= '0;
    end else begin
      state    <= state_nx;
      cmd_rdy  <= cmd_rdy_nx;
      aw_valid <= aw_valid_nx;
      w_valid  <= w_valid_nx;
      ar_valid <= ar_valid_nx;
      b_ready  <= b_ready_nx;
      r_ready  <= r_ready_nx;
      aw_done  <= aw_done_nx;
      w_done   <= w_done_nx;
      rsp_vld  <= rsp_vld_nx;
      we       <= we_nx;
      addr     <= addr_nx;
      wdata    <= wdata_nx;
      wstrb    <= wstrb_nx;
      rdata    <= rdata_nx;
      resp     <= resp_nx;
    end
  end

  assign cmd_ready     = cmd_rdy;
  assign rsp_valid     = rsp_vld;
  assign rsp_we        = we;
  assign rsp_rdata     = rdata;
  assign rsp_resp      = resp;
  assign M_AXI_AWVALID = aw_valid;
  assign M_AXI_AWADDR  = addr;
  assign M_AXI_AWPROT  = AXI_PROT_DEFAULT;
  assign M_AXI_WVALID  = w_valid;
  assign M_AXI_WDATA   = wdata;
  assign M_AXI_WSTRB   = wstrb;
  assign M_AXI_BREADY  = b_ready;
  assign M_AXI_ARVALID = ar_valid;
  assign M_AXI_ARADDR  = addr;
  assign M_AXI_ARPROT  = AXI_PROT_DEFAULT;
  assign M_AXI_RREADY  = r_ready;

`ifdef AXIL_MASTER_TIMEOUT_EN
  axil_mst_watchdog #(
    .LIMIT(C_TIMEOUT_CYCLES)
  ) u_wdog (
    .clk    (M_AXI_ACLK),
    .rst    (M_AXI_ARESET),
    .start  (state == IDLE && state_nx != IDLE),
    .active (state == WRITE || state == READ),
    .timeout(o_timeout)
  );
`endif

endmodule

// File: tb/tb_axil_single_master.sv
// Directed + randomized bench for axil_single_master with a delay-programmable
// AXI-Lite slave model and a reference memory kept at transaction level.
module tb_axil_single_master;
  import axil_pkg::*;

  localparam int AW = 7;
  localparam int DW = 32;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          cmd_valid = 0, cmd_ready, cmd_we = 0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [SW-1:0] cmd_wstrb = '0;
  logic          rsp_valid, rsp_ready = 0, rsp_we;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic [DW-1:0] wdata, rdata;
  logic [SW-1:0] wstrb;
  logic [1:0]    bresp, rresp;
`ifdef AXIL_MASTER_TIMEOUT_EN
  logic          o_timeout;
`endif

  int tests = 0;
  int fails = 0;

  axil_single_master dut (
    .M_AXI_ACLK   (clk),
    .M_AXI_ARESET (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_we       (cmd_we),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .cmd_wstrb    (cmd_wstrb),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_we       (rsp_we),
    .rsp_rdata    (rsp_rdata),
    .rsp_resp     (rsp_resp),
`ifdef AXIL_MASTER_TIMEOUT_EN
    .o_timeout    (o_timeout),
`endif
    .M_AXI_AWVALID(awvalid),
    .M_AXI_AWREADY(awready),
    .M_AXI_AWADDR (awaddr),
    .M_AXI_AWPROT (awprot),
    .M_AXI_WVALID (wvalid),
    .M_AXI_WREADY (wready),
    .M_AXI_WDATA  (wdata),
    .M_AXI_WSTRB  (wstrb),
    .M_AXI_BVALID (bvalid),
    .M_AXI_BREADY (bready),
    .M_AXI_BRESP  (bresp),
    .M_AXI_ARVALID(arvalid),
    .M_AXI_ARREADY(arready),
    .M_AXI_ARADDR (araddr),
    .M_AXI_ARPROT (arprot),
    .M_AXI_RVALID (rvalid),
    .M_AXI_RREADY (rready),
    .M_AXI_RDATA  (rdata),
    .M_AXI_RRESP  (rresp)
  );

  // Slave: upper two words answer with errors and ignore writes.
  function automatic logic [1:0] resp_of(input logic [AW-1:0] a);
    if (a[6:2] == 5'd31) return AXI_RESP_DECERR;
    if (a[6:2] == 5'd30) return AXI_RESP_SLVERR;
    return AXI_RESP_OKAY;
  endfunction

  logic [DW-1:0] smem [32];
  logic [DW-1:0] rmem [32];
  int aw_dly = 0, w_dly = 0, ar_dly = 0;
  int aw_cnt, w_cnt, ar_cnt;
  int n_aw = 0, n_w = 0, n_ar = 0, n_b = 0, n_r = 0;
  logic got_aw, got_w;
  logic [AW-1:0] s_awaddr;
  logic [DW-1:0] s_wdata;
  logic [SW-1:0] s_wstrb;
  logic r_ovr = 0;
  logic [DW-1:0] ovr_data = '0;
  logic [1:0] ovr_resp = '0;

  always @(posedge clk) begin
    if (rst) begin
      awready <= 0; wready <= 0; arready <= 0;
      bvalid <= 0; rvalid <= 0; got_aw <= 0; got_w <= 0;
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
      bresp <= 0; rresp <= 0; rdata <= 0;
    end else begin
      awready <= 0;
      wready  <= 0;
      arready <= 0;
      if (awvalid && awready) begin
        got_aw <= 1; s_awaddr <= awaddr; n_aw <= n_aw + 1; aw_cnt <= 0;
      end else if (awvalid) begin
        if (aw_cnt >= aw_dly) awready <= 1; else aw_cnt <= aw_cnt + 1;
      end
      if (wvalid && wready) begin
        got_w <= 1; s_wdata <= wdata; s_wstrb <= wstrb; n_w <= n_w + 1; w_cnt <= 0;
      end else if (wvalid) begin
        if (w_cnt >= w_dly) wready <= 1; else w_cnt <= w_cnt + 1;
      end
      if (bvalid && bready) begin
        bvalid <= 0; n_b <= n_b + 1;
      end else if (!bvalid && got_aw && got_w) begin
        bvalid <= 1; bresp <= resp_of(s_awaddr);
        got_aw <= 0; got_w <= 0;
        if (resp_of(s_awaddr) == AXI_RESP_OKAY)
          for (int b = 0; b < SW; b++)
            if (s_wstrb[b]) smem[s_awaddr[6:2]][8*b +: 8] <= s_wdata[8*b +: 8];
      end
      if (rvalid && rready) begin
        rvalid <= 0; n_r <= n_r + 1;
      end
      if (arvalid && arready) begin
        n_ar <= n_ar + 1; ar_cnt <= 0; rvalid <= 1;
        rdata <= r_ovr ? ovr_data : smem[araddr[6:2]];
        rresp <= r_ovr ? ovr_resp : resp_of(araddr);
      end else if (arvalid) begin
        if (ar_cnt >= ar_dly) arready <= 1; else ar_cnt <= ar_cnt + 1;
      end
    end
  end

  // VALID must hold, with stable payload, until READY
  logic p_rst = 1, p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
  logic [AW-1:0] p_awa, p_ara;
  logic [DW-1:0] p_wd;
  logic [SW-1:0] p_ws;
  always @(posedge clk) begin
    if (!rst && !p_rst) begin
      if (p_awv && !p_awr) begin
        tests++;
        assert (awvalid === 1'b1 && awaddr === p_awa) else begin
          fails++;
          $error("FAIL aw_hold observed=%0b/%0h expected=1/%0h", awvalid, awaddr, p_awa);
        end
      end
      if (p_wv && !p_wr) begin
        tests++;
        assert (wvalid === 1'b1 && wdata === p_wd && wstrb === p_ws) else begin
          fails++;
          $error("FAIL w_hold observed=%0b/%0h/%0h expected=1/%0h/%0h", wvalid, wdata, wstrb, p_wd, p_ws);
        end
      end
      if (p_arv && !p_arr) begin
        tests++;
        assert (arvalid === 1'b1 && araddr === p_ara) else begin
          fails++;
          $error("FAIL ar_hold observed=%0b/%0h expected=1/%0h", arvalid, araddr, p_ara);
        end
      end
    end
    p_rst = rst;
    p_awv = awvalid; p_awr = awready; p_awa = awaddr;
    p_wv = wvalid; p_wr = wready; p_wd = wdata; p_ws = wstrb;
    p_arv = arvalid; p_arr = arready; p_ara = araddr;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_txn(input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s,
                         input int hold, input string tag);
    logic [DW-1:0] e_data;
    logic [1:0] e_resp;
    logic [DW-1:0] h_data;
    logic [1:0] h_resp;
    int lat, e_lat, aw0, w0, b0, ar0, r0;
    bit bad;
    if (we) begin
      e_resp = resp_of(a);
      e_data = '0;
      e_lat = 5 + (aw_dly > w_dly ? aw_dly : w_dly);
      if (e_resp == AXI_RESP_OKAY)
        for (int b = 0; b < SW; b++)
          if (s[b]) rmem[a[6:2]][8*b +: 8] = d[8*b +: 8];
    end else begin
      e_resp = r_ovr ? ovr_resp : resp_of(a);
      e_data = r_ovr ? ovr_data : rmem[a[6:2]];
      e_lat = 4 + ar_dly;
    end
    aw0 = n_aw; w0 = n_w; b0 = n_b; ar0 = n_ar; r0 = n_r;
    bad = 0;
    @(negedge clk);
    cmd_valid = 1; cmd_we = we; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    lat = 0;
    while (!cmd_ready && lat < 20) begin @(negedge clk); lat++; end
    check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    rsp_ready = (hold == 0);
    @(negedge clk);
    cmd_valid = 0;
    lat = 1;
    while (!rsp_valid && lat < 200) begin
      if (we) begin
        if (n_w > w0 && wvalid) bad = 1;
        if (n_aw > aw0 && awvalid) bad = 1;
        if (bready && !(n_aw > aw0 && n_w > w0)) bad = 1;
      end else begin
        if (n_ar > ar0 && arvalid) bad = 1;
        if (rready && n_ar == ar0) bad = 1;
      end
      @(negedge clk);
      lat++;
    end
    check({tag, "_order"}, 64'(bad), 64'd0);
    check({tag, "_latency"}, 64'(lat), 64'(e_lat));
    check({tag, "_rsp"}, {rsp_valid, rsp_we, rsp_resp, rsp_rdata},
          {1'b1, we, e_resp, e_data});
    h_data = rsp_rdata;
    h_resp = rsp_resp;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold"},
            {rsp_valid, rsp_resp, rsp_rdata, cmd_ready, awvalid, wvalid, arvalid},
            {1'b1, h_resp, h_data, 4'b0000});
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    check({tag, "_done"}, {rsp_valid, cmd_ready}, 2'b01);
    check({tag, "_hs"},
          {4'(n_aw - aw0), 4'(n_w - w0), 4'(n_b - b0), 4'(n_ar - ar0), 4'(n_r - r0)},
          we ? 20'h11100 : 20'h00011);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] stuck");
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      smem[i] = 32'h0101_0101 * i;
      rmem[i] = 32'h0101_0101 * i;
    end

    // reset values
    repeat (3) @(negedge clk);
    check("reset_outs",
          {cmd_ready, rsp_valid, awvalid, wvalid, arvalid, bready, rready},
          7'd0);
    check("reset_regs", {rsp_rdata, rsp_resp, awaddr, wdata, wstrb}, '0);
    rst = 0;
    @(negedge clk);
    check("post_reset_ready", 64'(cmd_ready), 64'd1);
    check("prot_const", {awprot, arprot}, 6'd0);

    // 1: zero-wait write
    run_txn(1, 7'h40, 32'h8000_0000, 4'b1000, 0, "t1");
    // 2: W accepted 3 cycles before AW
    aw_dly = 3; w_dly = 0;
    run_txn(1, 7'h40, 32'h1234_5678, 4'b0101, 0, "t2");
    aw_dly = 0;
    // zero-wait read of the merged word
    run_txn(0, 7'h40, '0, '0, 0, "rd40");
    // 3: delayed AR with slave error data
    ar_dly = 4; r_ovr = 1; ovr_data = 32'hDEAD_BEEF; ovr_resp = AXI_RESP_SLVERR;
    run_txn(0, 7'h44, '0, '0, 0, "t3");
    r_ovr = 0; ar_dly = 0;
    // 4: response back-pressure
    run_txn(1, 7'h7C, 32'hCAFE_F00D, 4'b1111, 6, "t4");
    run_txn(0, 7'h08, '0, '0, 6, "t4r");

    // 5: reset while AW is outstanding
    aw_dly = 20;
    @(negedge clk);
    cmd_valid = 1; cmd_we = 1; cmd_addr = 7'h40; cmd_wdata = 32'h5555_AAAA; cmd_wstrb = 4'hF;
    @(negedge clk);
    cmd_valid = 0;
    check("t5_awvalid", 64'(awvalid), 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    check("t5_rst_outs",
          {awvalid, wvalid, arvalid, bready, rready, rsp_valid, cmd_ready}, 7'd0);
    rst = 0;
    @(negedge clk);
    check("t5_release", {cmd_ready, rsp_valid}, 2'b10);
    aw_dly = 0;
    run_txn(0, 7'h40, '0, '0, 0, "t5r");

    // randomized traffic
    for (int k = 0; k < 24; k++) begin
      aw_dly = $urandom_range(0, 3);
      w_dly  = $urandom_range(0, 3);
      ar_dly = $urandom_range(0, 3);
      run_txn(1'($urandom_range(0, 1)), {5'($urandom_range(0, 31)), 2'b00},
              $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2), "rnd");
    end
    aw_dly = 0; w_dly = 0; ar_dly = 0;

`ifdef AXIL_MASTER_TIMEOUT_EN
    // 6: stalled AR trips the watchdog without aborting the read
    ar_dly = 30;
    @(negedge clk);
    cmd_valid = 1; cmd_we = 0; cmd_addr = 7'h10;
    @(negedge clk);
    cmd_valid = 0;
    repeat (14) @(negedge clk);
    check("t6_before", 64'(o_timeout), 64'd0);
    @(negedge clk);
    check("t6_flag", {o_timeout, arvalid}, 2'b11);
    rsp_ready = 1;
    for (int i = 0; i < 60 && !rsp_valid; i++) @(negedge clk);
    check("t6_rsp", {rsp_valid, rsp_rdata}, {1'b1, rmem[4]});
    @(negedge clk);
    rsp_ready = 0;
    check("t6_sticky", 64'(o_timeout), 64'd1);
    ar_dly = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
